// File: rtl/sm9_pkg.sv
// Shared constants for the SM9 scalar-multiplication host I/O stage:
// curve order, bus width, FSM state codes and operand select codes.
package sm9_pkg;

  localparam int BUS_W_DEF = 32;
  localparam int OP_W      = 256;

  localparam logic [OP_W-1:0] SM9_N =
    256'hB640000002A3A6F1D603AB4FF58EC74449F2934B18EA8BEEE56EE19CD69ECF25;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHK   = 3'd1;
  localparam logic [2:0] ST_CLR   = 3'd2;
  localparam logic [2:0] ST_GO    = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_CAPT  = 3'd5;
  localparam logic [2:0] ST_RDOUT = 3'd6;

  localparam logic [1:0] SEL_K = 2'd0;
  localparam logic [1:0] SEL_X = 2'd1;
  localparam logic [1:0] SEL_Y = 2'd2;

endpackage

// File: rtl/sm9_word_unpack.sv
// Holds the 512-bit result (x1 above y1) and streams it out one bus word
// per pop, most-significant word first, with rd_valid one cycle after pop.
module sm9_word_unpack
  import sm9_pkg::*;
#(
  parameter  int BUS_W  = BUS_W_DEF,
  localparam int NWORDS = 2 * OP_W / BUS_W,
  localparam int IDX_W  = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              capture,
  input  logic              clear,
  input  logic [2*OP_W-1:0] res_in,
  input  logic              idx_clr,
  input  logic              pop,
  output logic [IDX_W-1:0]  idx,
  output logic [BUS_W-1:0]  rd_data,
  output logic              rd_valid
);

  logic [2*OP_W-1:0] res;
  logic [BUS_W-1:0]  words [NWORDS];

  for (genvar i = 0; i < NWORDS; i++) begin : g_words
    assign words[i] = res[2*OP_W-1-i*BUS_W -: BUS_W];
  end

  // NOTE: the result register is reset like any other state so a rejected or
  // aborted operation can never leak a previous scalar-multiplication result.
  always_ff @(posedge clk) begin
    if (!rst_b)       res <= '0;
    else if (clear)   res <= '0;
    else if (capture) res <= res_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      idx      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= words[idx];
      if (idx_clr)  idx <= '0;
      else if (pop) idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sm9_mult_io.sv
// Host load/unload stage around the SM9 scalar-multiplication core.
// Define SM9_SCALAR_RANGE_CHECK_EN to also reject scalars k >= N.
module sm9_mult_io
  import sm9_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [BUS_W-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             rd_en,
  output logic [BUS_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             core_rst_b,
  output logic             core_en,
  output logic [OP_W-1:0]  core_l,
  output logic [OP_W-1:0]  core_x0,
  output logic [OP_W-1:0]  core_y0,
  input  logic [OP_W-1:0]  core_x1,
  input  logic [OP_W-1:0]  core_y1,
  input  logic             core_sign
);

  localparam int IDX_W = $clog2(2 * OP_W / BUS_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * OP_W / BUS_W - 1);

  logic [2:0]      state, state_nxt;
  logic [OP_W-1:0] k_reg, x_reg, y_reg;
  logic            err_q;
  logic            reject;
  logic            pop;
  logic            last;
  logic [IDX_W-1:0] idx;

`ifdef SM9_SCALAR_RANGE_CHECK_EN
  assign reject = (k_reg == '0) || (k_reg >= SM9_N);
`else
  assign reject = (k_reg == '0);
`endif

  assign pop  = rd_en && (state == ST_RDOUT);
  assign last = pop && (err_q || (idx == LAST_IDX));

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CHK;
      ST_CHK:   state_nxt = reject ? ST_RDOUT : ST_CLR;
      ST_CLR:   state_nxt = ST_GO;
      ST_GO:    state_nxt = ST_WAIT;
      ST_WAIT:  if (core_sign) state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_RDOUT;
      ST_RDOUT: if (last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      k_reg <= '0;
      x_reg <= '0;
      y_reg <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && wr_en) begin
        case (wr_sel)
          SEL_K:   k_reg <= {k_reg[OP_W-BUS_W-1:0], wr_data};
          SEL_X:   x_reg <= {x_reg[OP_W-BUS_W-1:0], wr_data};
          SEL_Y:   y_reg <= {y_reg[OP_W-BUS_W-1:0], wr_data};
          default: ;
        endcase
      end
      if (state == ST_CHK)  err_q <= reject;
      if (state == ST_CAPT) err_q <= 1'b0;
    end
  end

  // Core reset follows the host reset combinationally so the core is held
  // in reset for the whole time rst_b is low, not just from the next edge.
  assign core_rst_b = rst_b && (state != ST_CLR);
  assign core_en    = (state == ST_GO);
  assign core_l     = k_reg;
  assign core_x0    = x_reg;
  assign core_y0    = y_reg;
  assign busy       = (state != ST_IDLE) && (state != ST_RDOUT);
  assign done       = (state == ST_RDOUT);
  assign err        = done && err_q;

  sm9_word_unpack #(.BUS_W(BUS_W)) u_unpack (
    .clk      (clk),
    .rst_b    (rst_b),
    .capture  (state == ST_CAPT),
    .clear    ((state == ST_CHK) && reject),
    .res_in   ({core_x1, core_y1}),
    .idx_clr  (state != ST_RDOUT),
    .pop      (pop),
    .idx      (idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_sm9_mult_io.sv
// Directed bench for sm9_mult_io with a stub core (sticky sign, programmable
// latency). Honours SM9_SCALAR_RANGE_CHECK_EN the same way as the design.
module tb_sm9_mult_io;
  import sm9_pkg::*;

  localparam logic [255:0] P1X = 256'h93DE051D62BF718FF5ED0704487D01D6E1E4086909DC3280E8C4E4817C66DDDD;
  localparam logic [255:0] P1Y = 256'h21FE8DDA4F21E607631065125C395BBC1C1C00CBFA6024350C464CD70A3EA616;
  localparam logic [255:0] PAT_A = {8{32'hAAAAAAAA}};
  localparam logic [255:0] PAT_5 = {8{32'h55555555}};

  logic         clk = 1'b0;
  logic         rst_b, wr_en, start, rd_en;
  logic [1:0]   wr_sel;
  logic [31:0]  wr_data;
  logic         busy, done, err, rd_valid, core_rst_b, core_en;
  logic [31:0]  rd_data;
  logic [255:0] core_l, core_x0, core_y0, core_x1, core_y1;
  logic         core_sign;

  int total = 0;
  int bad   = 0;

  sm9_mult_io dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .err(err), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .core_rst_b(core_rst_b), .core_en(core_en),
    .core_l(core_l), .core_x0(core_x0), .core_y0(core_y0), .core_x1(core_x1),
    .core_y1(core_y1), .core_sign(core_sign)
  );

  always #5 clk = ~clk;

  // Stub core: sign rises stub_lat cycles after core_en, sticky until core reset.
  int           stub_lat = 20;
  int           stub_cnt;
  logic         stub_run;
  logic [255:0] stub_x1, stub_y1;
  assign core_x1 = stub_x1;
  assign core_y1 = stub_y1;

  always_ff @(posedge clk) begin
    if (!core_rst_b) begin
      core_sign <= 1'b0;
      stub_run  <= 1'b0;
      stub_cnt  <= 0;
    end else if (core_en) begin
      stub_run <= 1'b1;
      stub_cnt <= stub_lat;
    end else if (stub_run) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        core_sign <= 1'b1;
        stub_run  <= 1'b0;
      end
    end
  end

  int en_cnt  = 0;
  int clr_cnt = 0;
  always @(posedge clk) begin
    if (core_en) en_cnt++;
    if (rst_b && !core_rst_b) clr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic load_op(input logic [255:0] k, input logic [255:0] x, input logic [255:0] y);
    logic [255:0] v [3];
    v[0] = k; v[1] = x; v[2] = y;
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < 8; w++) begin
        wr_en = 1'b1; wr_sel = 2'(s); wr_data = v[s][255-32*w -: 32];
        tick();
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done timeout cycles=%0d", cyc);
    end
  endtask

  task automatic run_op(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, cyc);
  endtask

  task automatic read_all(input string name, input logic [511:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp[511-32*i -: 32]) begin
        bad++;
        $display("FAIL %s word%0d got=%h valid=%b exp=%h", name, i, rd_data, rd_valid, exp[511-32*i -: 32]);
      end
    end
    rd_en = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end done=%b busy=%b exp 0 0", name, done, busy);
    end
    tick();
    chk({name, " rd_valid_drop"}, 256'(rd_valid), 256'd0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; wr_en = 1'b0; wr_sel = 2'd0; wr_data = '0; start = 1'b0; rd_en = 1'b0;
    stub_x1 = '0; stub_y1 = '0;
    repeat (3) tick();
    chk("rst busy", 256'(busy), 256'd0);
    chk("rst done", 256'(done), 256'd0);
    chk("rst err", 256'(err), 256'd0);
    chk("rst rd_valid", 256'(rd_valid), 256'd0);
    chk("rst rd_data", 256'(rd_data), 256'd0);
    chk("rst core_rst_b", 256'(core_rst_b), 256'd0);
    chk("rst core_en", 256'(core_en), 256'd0);
    chk("rst core_l", core_l, 256'd0);
    rst_b = 1'b1;
    tick();
    chk("rel core_rst_b", 256'(core_rst_b), 256'd1);
    chk("rel busy", 256'(busy), 256'd0);
  endtask

  task automatic test_normal();
    int cyc, en0, clr0;
    load_op(256'd1, P1X, P1Y);
    chk("load core_l", core_l, 256'd1);
    chk("load core_x0", core_x0, P1X);
    chk("load core_y0", core_y0, P1Y);
    stub_lat = 20; stub_x1 = PAT_A; stub_y1 = PAT_5;
    en0 = en_cnt; clr0 = clr_cnt;
    run_op(cyc);
    chk("normal latency", 256'(cyc), 256'd26);
    chk("normal core_en pulses", 256'(en_cnt - en0), 256'd1);
    chk("normal clr pulses", 256'(clr_cnt - clr0), 256'd1);
    chk("normal err", 256'(err), 256'd0);
    chk("normal busy", 256'(busy), 256'd0);
    read_all("normal", {PAT_A, PAT_5}, 16);
  endtask

  task automatic test_zero_k();
    int cyc, en0, clr0;
    load_op(256'd0, P1X, P1Y);
    en0 = en_cnt; clr0 = clr_cnt;
    run_op(cyc);
    chk("zero latency", 256'(cyc), 256'd2);
    chk("zero err", 256'(err), 256'd1);
    chk("zero core_en", 256'(en_cnt - en0), 256'd0);
    chk("zero clr", 256'(clr_cnt - clr0), 256'd0);
    read_all("zero", 512'd0, 1);
  endtask

  task automatic test_range();
    int cyc;
    stub_lat = 8; stub_x1 = PAT_5; stub_y1 = PAT_A;
    load_op(SM9_N, P1X, P1Y);
    chk("rangeN core_l", core_l, SM9_N);
    run_op(cyc);
`ifdef SM9_SCALAR_RANGE_CHECK_EN
    chk("rangeN latency", 256'(cyc), 256'd2);
    chk("rangeN err", 256'(err), 256'd1);
    read_all("rangeN", 512'd0, 1);
`else
    chk("rangeN latency", 256'(cyc), 256'd14);
    chk("rangeN err", 256'(err), 256'd0);
    read_all("rangeN", {PAT_5, PAT_A}, 16);
`endif
    load_op(SM9_N - 256'd1, P1X, P1Y);
    run_op(cyc);
    chk("rangeN-1 latency", 256'(cyc), 256'd14);
    chk("rangeN-1 err", 256'(err), 256'd0);
    read_all("rangeN-1", {PAT_5, PAT_A}, 16);
  endtask

  task automatic test_wait_disturb();
    int cyc, en0;
    stub_lat = 30; stub_x1 = PAT_A; stub_y1 = PAT_A;
    load_op(256'd7, P1X, P1Y);
    en0 = en_cnt;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    wr_en = 1'b1; wr_sel = SEL_K; wr_data = 32'hDEADBEEF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("wait core_l kept", core_l, 256'd7);
    chk("wait busy", 256'(busy), 256'd1);
    wait_done(7, cyc);
    chk("wait latency", 256'(cyc), 256'd36);
    chk("wait no restart", 256'(en_cnt - en0), 256'd1);
    read_all("wait", {PAT_A, PAT_A}, 16);
    // Abort an operation in WAIT.
    load_op(256'd5, P1X, P1Y);
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    rst_b = 1'b0;
    #1;
    chk("abort core_rst_b", 256'(core_rst_b), 256'd0);
    tick();
    chk("abort busy", 256'(busy), 256'd0);
    chk("abort done", 256'(done), 256'd0);
    chk("abort core_l", core_l, 256'd0);
    rst_b = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("idle rd_valid", 256'(rd_valid), 256'd0);
    chk("idle core_rst_b", 256'(core_rst_b), 256'd1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [511:0] exp;
    stub_lat = 10; stub_x1 = PAT_A; stub_y1 = PAT_5;
    load_op(256'd2, P1X, P1Y);
    run_op(cyc);
    chk("b2b1 latency", 256'(cyc), 256'd16);
    read_all("b2b1", {PAT_A, PAT_5}, 16);
    chk("b2b stale sign", 256'(core_sign), 256'd1);
    for (int i = 0; i < 16; i++) exp[511-32*i -: 32] = 32'h10203000 + 32'(i);
    stub_lat = 15; stub_x1 = exp[511:256]; stub_y1 = exp[255:0];
    load_op(256'd3, P1X, P1Y);
    run_op(cyc);
    chk("b2b2 latency", 256'(cyc), 256'd21);
    chk("b2b2 err", 256'(err), 256'd0);
    read_all("b2b2", exp, 16);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_k();
    test_range();
    test_wait_disturb();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
